validator_scheduler: RTL and testbench

- Sequences the neighbour-search datapath over a stored point cloud. Point-under-test p runs 0..size-1.
- Per point: fetches intensity, applies the intensity bypass, then sweeps candidate batches of DISTANCE_MODULES addresses into the distance lanes.
- Accumulates masked per-lane hits, issues one inlier/outlier verdict per point over a valid/ready handshake.
- Sits between point memory, the distance-lane array and the result writer.

---
 rtl/validator_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_validator_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/validator_scheduler.sv
// validator_scheduler: sequences the neighbour-search datapath over a stored point cloud.
//
// Each point p in 0..size-1 is fetched. A bright point (pt_i > INTENSITY_TRESHOLD) becomes an
// inlier at once. Any other point sweeps all candidates in batches of DISTANCE_MODULES lanes.
// The masked hit flags that come back are counted, saturating at NEIGHBOR_TRESHOLD, and one
// verdict per point is offered on a valid/ready handshake.
//
// Optional feature: define VALIDATOR_EARLY_TERM_EN to stop issuing batches as soon as the
// neighbour count saturates. Verdicts stay the same; only batch count and latency change.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start               pulse, begins a run when idle
//   point_cloud_size    number of points, sampled on an accepted start
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pt_rd_en, pt_addr   point-under-test read; pt_i returns one cycle later
//   batch_rd_en,        candidate batch issue; lane k compares against point batch_addr+k
//   batch_addr
//   hits                per-lane within-radius flags, PIPE_LAT cycles after batch_rd_en
//   result_*            verdict handshake (valid/ready, inlier flag, point index)
module validator_scheduler #(
  parameter int unsigned N                  = 16,
  parameter int unsigned DISTANCE_MODULES   = 8,
  parameter int unsigned PIPE_LAT           = 3,
  parameter int unsigned NEIGHBOR_TRESHOLD  = 5,
  parameter int unsigned INTENSITY_TRESHOLD = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2*N-1:0]              point_cloud_size,
  output logic                        busy,
  output logic                        done,
  output logic                        pt_rd_en,
  output logic [2*N-1:0]              pt_addr,
  input  logic [N-1:0]                pt_i,
  output logic                        batch_rd_en,
  output logic [2*N-1:0]              batch_addr,
  input  logic [DISTANCE_MODULES-1:0] hits,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        result_inlier,
  output logic [2*N-1:0]              result_index
);

  localparam int unsigned AW   = 2 * N;
  localparam int unsigned DM   = DISTANCE_MODULES;
  localparam int unsigned CntW = $clog2(NEIGHBOR_TRESHOLD + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StCheck, StSweep, StDrain, StEmit} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   size_q, size_d;
  logic [AW-1:0]   p_q, p_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inlier_q, inlier_d;
  logic            done_q, done_d;

  // One valid bit and lane mask per batch in flight, aligned with the returning hits.
  logic [PIPE_LAT-1:0]         pv_q;
  logic [PIPE_LAT-1:0][DM-1:0] pm_q;

  logic          issue;
  logic [DM-1:0] lane_mask;
  logic [AW:0]   lane_addr;
  logic [31:0]   pop;
  logic [31:0]   acc;
  logic [CntW-1:0] count_acc;
  logic          inflight;
  logic          sweep_last;

  // Lane k is live only for an in-range candidate other than the point itself.
  always_comb begin
    lane_mask = '0;
    lane_addr = '0;
    for (int k = 0; k < DM; k++) begin
      lane_addr    = {1'b0, base_q} + (AW + 1)'(k);
      lane_mask[k] = (lane_addr < {1'b0, size_q}) && (lane_addr != {1'b0, p_q});
    end
  end

  assign sweep_last = ({1'b0, base_q} + (AW + 1)'(DM)) >= {1'b0, size_q};

  // Returning hits are counted in every state; the count only ever saturates upward.
  always_comb begin
    pop = '0;
    for (int k = 0; k < DM; k++) begin
      pop = pop + 32'(hits[k] & pm_q[PIPE_LAT-1][k]);
    end
    acc       = 32'(count_q) + (pv_q[PIPE_LAT-1] ? pop : 32'd0);
    count_acc = (acc >= NEIGHBOR_TRESHOLD) ? CntW'(NEIGHBOR_TRESHOLD) : CntW'(acc);
  end

  // Anything still in flight other than the entry completing this cycle.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
      inflight = inflight | pv_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    p_d      = p_q;
    base_d   = base_q;
    count_d  = count_acc;
    inlier_d = inlier_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (point_cloud_size != '0) begin
            size_d  = point_cloud_size;
            p_d     = '0;
            state_d = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: state_d = StCheck;
      StCheck: begin
        if (pt_i > N'(INTENSITY_TRESHOLD)) begin
          inlier_d = 1'b1;
          state_d  = StEmit;
        end else begin
          base_d  = '0;
          count_d = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        issue  = 1'b1;
        base_d = base_q + AW'(DM);
        if (sweep_last) state_d = StDrain;
`ifdef VALIDATOR_EARLY_TERM_EN
        if (count_acc == CntW'(NEIGHBOR_TRESHOLD)) state_d = StDrain;
`endif
      end
      StDrain: begin
        // Final entry's hits are folded in via count_acc, saving a cycle.
        if (!inflight) begin
          inlier_d = (count_acc == CntW'(NEIGHBOR_TRESHOLD));
          state_d  = StEmit;
        end
      end
      StEmit: begin
        if (result_ready) begin
          p_d = p_q + 1'b1;
          if (p_q == size_q - 1'b1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      size_q   <= '0;
      p_q      <= '0;
      base_q   <= '0;
      count_q  <= '0;
      inlier_q <= 1'b0;
      done_q   <= 1'b0;
      pv_q     <= '0;
      pm_q     <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      p_q      <= p_d;
      base_q   <= base_d;
      count_q  <= count_d;
      inlier_q <= inlier_d;
      done_q   <= done_d;
      pv_q[0]  <= issue;
      pm_q[0]  <= issue ? lane_mask : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pm_q[i] <= pm_q[i-1];
      end
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign pt_rd_en      = (state_q == StFetch);
  assign pt_addr       = pt_rd_en ? p_q : '0;
  assign batch_rd_en   = issue;
  assign batch_addr    = issue ? base_q : '0;
  assign result_valid  = (state_q == StEmit);
  assign result_inlier = result_valid & inlier_q;
  assign result_index  = result_valid ? p_q : '0;

endmodule

// File: tb/tb_validator_scheduler.sv
// Directed bench for validator_scheduler: table of whole-run vectors plus hand-written
// sequences for size 0, back-pressure and reset with batches in flight.
module tb_validator_scheduler;

  localparam int N  = 16;
  localparam int DM = 8;
  localparam int PL = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   pcs = '0;
  logic          busy, done, pt_rd_en, batch_rd_en, result_valid, result_inlier;
  logic [31:0]   pt_addr, batch_addr, result_index;
  logic [N-1:0]  pt_i = '0;
  logic [DM-1:0] hits;
  logic          result_ready = 1'b0;

  validator_scheduler #(
    .N(N), .DISTANCE_MODULES(DM), .PIPE_LAT(PL), .NEIGHBOR_TRESHOLD(5), .INTENSITY_TRESHOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .point_cloud_size(pcs),
    .busy(busy), .done(done), .pt_rd_en(pt_rd_en), .pt_addr(pt_addr), .pt_i(pt_i),
    .batch_rd_en(batch_rd_en), .batch_addr(batch_addr), .hits(hits),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_inlier(result_inlier), .result_index(result_index)
  );

  always #5 clock = ~clock;

  // Memory and lane-array responders: intensity one cycle after the read, hit pattern
  // PL cycles after each batch, random garbage otherwise.
  logic [N-1:0]  pt_val  = '0;
  logic [DM-1:0] hit_pat = '0;
  logic [DM-1:0] garbage = '0;
  logic [PL-1:0] rd_dly  = '0;
  always @(posedge clock) begin
    pt_i    <= pt_rd_en ? pt_val : N'($urandom);
    rd_dly  <= {rd_dly[PL-2:0], batch_rd_en};
    garbage <= DM'($urandom);
  end
  assign hits = rd_dly[PL-1] ? hit_pat : garbage;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          size;
    logic [15:0] ptv;
    logic [7:0]  pat;
    int          stall;
    logic [31:0] exp_mask;
    int          nbatch;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    int n, c0, nb;
    logic       inl0;
    logic [31:0] idx0;
    pt_val  = v.ptv;
    hit_pat = v.pat;
    pcs     = 32'(v.size);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int p = 0; p < v.size; p++) begin
      n = 0;
      while (!pt_rd_en && n < 200) begin step(); n++; end
      if (!pt_rd_en) begin chk("fetch_timeout", 0, 1); return; end
      chk("pt_addr", pt_addr, p);
      c0 = cyc;
      nb = 0;
      n  = 0;
      while (!result_valid && n < 200) begin
        nb += int'(batch_rd_en);
        step();
        n++;
      end
      if (!result_valid) begin chk("result_timeout", 0, 1); return; end
`ifndef VALIDATOR_EARLY_TERM_EN
      chk("latency", cyc - c0, v.lat);
      chk("batches", nb, v.nbatch);
`endif
      chk("result_index", result_index, p);
      chk("result_inlier", result_inlier, v.exp_mask[p]);
      inl0 = result_inlier;
      idx0 = result_index;
      for (int s = 0; s < v.stall; s++) begin
        // A start while busy must be ignored.
        start = (s == 0);
        pcs   = 32'd3;
        step();
        chk("stall_valid", result_valid, 1);
        chk("stall_inlier", result_inlier, inl0);
        chk("stall_index", result_index, idx0);
        chk("stall_no_fetch", pt_rd_en, 0);
      end
      start        = 1'b0;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_clear", busy, 0);
    chk("valid_clear", result_valid, 0);
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    vec_t rv;
    int   n;
    vecs[0] = '{20, 16'd0, 8'hFF, 0, 32'hFFFFF, 3, 8};
    vecs[1] = '{20, 16'd9, 8'h00, 0, 32'hFFFFF, 0, 2};
    vecs[2] = '{10, 16'd0, 8'hFF, 0, 32'h003FF, 2, 7};
    vecs[3] = '{1,  16'd0, 8'hFF, 0, 32'h00000, 1, 6};
    vecs[4] = '{6,  16'd0, 8'hFF, 5, 32'h0003F, 1, 6};
    vecs[5] = '{5,  16'd0, 8'hFF, 0, 32'h00000, 1, 6};
    vecs[6] = '{20, 16'd4, 8'h81, 0, 32'hE7E7E, 3, 8};
    vecs[7] = '{9,  16'd5, 8'h00, 2, 32'h001FF, 0, 2};

    #1;
    chk("reset_flags", {busy, done, pt_rd_en, batch_rd_en, result_valid, result_inlier}, 0);
    chk("reset_addrs", pt_addr | batch_addr | result_index, 0);
    step();
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Empty cloud: done pulse only.
    pcs   = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("size0_done", done, 1);
    chk("size0_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("size0_quiet", {done, busy, result_valid}, 0);
    end

    // Reset with batches in flight, then a run whose verdicts would flip if stale hits leaked.
    pt_val  = '0;
    hit_pat = 8'hFF;
    pcs     = 32'd20;
    start   = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!batch_rd_en && n < 50) begin step(); n++; end
    chk("sweep_reached", batch_rd_en, 1);
    step();
    reset = 1'b0;
    #1;
    chk("midrun_reset_flags",
        {busy, done, pt_rd_en, batch_rd_en, result_valid, result_inlier}, 0);
    chk("midrun_reset_addrs", pt_addr | batch_addr | result_index, 0);
    step();
    reset = 1'b1;
    rv = '{5, 16'd0, 8'hFF, 0, 32'h00000, 1, 6};
    run_vec(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
